alu_wb_slave: RTL and testbench
===============================

# alu_wb_slave

Wishbone classic responder that gives the control unit an arithmetic coprocessor on the shared peripheral bus, alongside the UART and frequency-counter slaves. The control unit writes two 32-bit operands and an opcode, then polls status and reads a 64-bit result. Single-cycle logic ops run alongside iterative 32-cycle multiply and divide engines. Bus outputs are zero whenever the block is not responding, because the top level ORs them onto the shared bus.

## Interface
- BASE_ADDR, 32'h0000_0300: block selected when addr_i[31:8] == BASE_ADDR[31:8].
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous, active-high reset.
- addr_i  in  32  byte address; offset is addr_i[7:0].
- dat_i  in  32  write data.
- dat_o  out  32  read data; 0 except during a read ack cycle.
- we_i  in  1  write enable.
- sel_i  in  4  byte lanes.
- cyc_i, stb_i  in  1 each  bus cycle and strobe.
- lock_i, tagn_i  in  1 each  ignored.
- ack_o, err_o, rty_o  out  1 each  single-cycle responses.
- tagn_o  out  1  tied to 0.
- busy_o  out  1  an operation is in progress (debug LED).

## Operation
- Register map (word offsets):
  - 0x00 OPA (RW).
  - 0x04 OPB (RW).
  - 0x08 CTRL (W: bits[2:0] opcode; write starts the operation; reads as last opcode).
  - 0x0C STATUS (R: bit0 busy, bit1 done, bit2 div0).
  - 0x10 RES_LO (R).
  - 0x14 RES_HI (R).
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR: result to RES_LO; RES_HI gets the carry/borrow in bit0 for ADD/SUB, else 0.
  - 5 MUL: unsigned 32x32 to 64, shift-add.
  - 6 DIV: unsigned restoring divide; RES_LO = quotient, RES_HI = remainder.
  - 7 is reserved and gets err.
- FSM states and transitions:
  - IDLE: CTRL write goes to EXEC (logic ops) or ITER (MUL/DIV).
  - EXEC: one cycle, then DONE.
  - ITER: 32 iterations, iteration counter 5 bits and wraps, then DONE.
  - DONE: sets done, then returns to IDLE.
- At start, OPA/OPB are copied into internal working registers, so OPA/OPB writes while busy are accepted and do not affect the running op.
- A CTRL write while busy gets rty. The running op is not disturbed and nothing is latched.
- RES_LO/RES_HI update only at completion. Reads while busy return the previous result.
- The done flag is cleared by the next CTRL write.
- Divide by zero: quotient = 32'hFFFF_FFFF, remainder = OPA, div0 = 1, done after 1 cycle.
- OPA/OPB writes honour sel_i lanes. CTRL uses lane 0 only. Writes to STATUS/RES get err.
- Selected access to an unmapped offset, or a misaligned offset (addr_i[1:0] != 0), gets err with dat_o = 0.

## Timing
- Reset values: all registers, dat_o, ack_o, err_o, rty_o, busy_o and STATUS are 0. FSM goes to IDLE.
- A reset during ITER aborts immediately with no result update.
- Responses are registered: one of ack/err/rty is high exactly one cycle after cyc_i & stb_i & select is sampled.
- No response is generated in the cycle following a response. A held stb_i therefore gets one response every 2 cycles.
- The access is decoded when sampled; ack, err and rty are mutually exclusive.
- The CTRL write ack cycle is start cycle T. busy is high from T+1.
- Logic ops: result and done visible at T+2; busy is low at T+2.
- MUL/DIV: 32 ITER cycles T+1..T+32; result and done visible at T+33.
- Simultaneous CTRL write and completion in the same cycle: completion wins and the write gets rty.

## Configuration
- ALU_DIV_EN defined: the divider is built and opcode 6 works as specified.
- ALU_DIV_EN undefined: no divider logic; a CTRL write of opcode 6 gets err and nothing starts.

## Structure
- Shared package alu_pkg:
  - opcode constants.
  - register offset constants.
  - FSM state encoding.
  - STATUS bit positions.
- One sub-module, alu_iter_core: the 32-cycle MUL/DIV datapath with start/done handshake and 64-bit result.
- The bus decode, register file and FSM stay in alu_wb_slave.

## Test plan
- MUL, OPA = OPB = 32'hFFFF_FFFF: ack at T, busy at T+1..T+32, RES_HI = 32'hFFFF_FFFE, RES_LO = 32'h0000_0001, done at T+33.
- DIV, 100 / 7: RES_LO = 14, RES_HI = 2, div0 = 0. DIV 5 / 0: RES_LO = 32'hFFFF_FFFF, RES_HI = 5, div0 = 1.
- ADD 32'hFFFF_FFFF + 1: RES_LO = 0, RES_HI = 1 at T+2. SUB 0 - 1: RES_LO = 32'hFFFF_FFFF, RES_HI bit0 = 1.
- CTRL write at T+10 of a MUL: rty, no ack. Final result unchanged, done still at T+33.
- Read offset 0x18 and write 0x10: err, dat_o = 0. An access with addr_i outside BASE_ADDR gives no response and dat_o = 0.
- rst_i pulsed at T+15 of a DIV: next cycle STATUS = 0, RES = 0, busy_o = 0. With ALU_DIV_EN undefined, opcode 6 gets err.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the Wishbone ALU coprocessor: opcodes, register
// offsets, FSM states, STATUS bit positions and the single-cycle ALU function.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_MUL = 3'd5,
    OP_DIV = 3'd6,
    OP_RSV = 3'd7
  } op_e;

  localparam logic [7:0] OFF_OPA    = 8'h00;
  localparam logic [7:0] OFF_OPB    = 8'h04;
  localparam logic [7:0] OFF_CTRL   = 8'h08;
  localparam logic [7:0] OFF_STATUS = 8'h0C;
  localparam logic [7:0] OFF_RES_LO = 8'h10;
  localparam logic [7:0] OFF_RES_HI = 8'h14;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_ITER = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int unsigned STAT_BUSY = 0;
  localparam int unsigned STAT_DONE = 1;
  localparam int unsigned STAT_DIV0 = 2;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  sel);
    logic [31:0] r;
    r = old_val;
    for (int unsigned i = 0; i < 4; i++) begin
      if (sel[i]) r[8*i +: 8] = new_val[8*i +: 8];
    end
    return r;
  endfunction

  // Single-cycle results; OP_DIV only reaches here for a zero divisor.
  function automatic logic [63:0] exec_result(input op_e op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
    logic [32:0] s;
    logic [63:0] r;
    s = '0;
    case (op)
      OP_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        r = {31'b0, s};
      end
      OP_SUB: begin
        s = {1'b0, a} - {1'b0, b};
        r = {31'b0, s};
      end
      OP_AND:  r = {32'b0, a & b};
      OP_OR:   r = {32'b0, a | b};
      OP_XOR:  r = {32'b0, a ^ b};
      OP_DIV:  r = {a, 32'hFFFF_FFFF};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_iter_core.sv
// 32-step shift-add multiplier and (with ALU_DIV_EN) restoring divider.
// res_next_o is the product/remainder:quotient after the current step.
module alu_iter_core (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        op_div_i,
  input  logic        en_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        done_o,
  output logic [63:0] res_next_o
);

  logic [31:0] opnd;
  logic [63:0] prod;
  logic [4:0]  cnt;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;

  assign mul_sum  = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, opnd} : 33'd0);
  assign mul_next = {mul_sum, prod[31:1]};
  assign done_o   = en_i && (cnt == 5'd31);

`ifdef ALU_DIV_EN
  logic        is_div;
  logic [32:0] trial;
  logic        fits;
  logic [31:0] rem;
  logic [63:0] div_next;

  // prod holds remainder:quotient; the quotient half shifts in the result bits.
  assign trial      = {prod[63:32], prod[31]};
  assign fits       = (trial >= {1'b0, opnd});
  assign rem        = fits ? (trial[31:0] - opnd) : trial[31:0];
  assign div_next   = {rem, prod[30:0], fits};
  assign res_next_o = is_div ? div_next : mul_next;
`else
  logic unused_ok;
  assign unused_ok  = op_div_i;
  assign res_next_o = mul_next;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      opnd <= '0;
      prod <= '0;
      cnt  <= '0;
`ifdef ALU_DIV_EN
      is_div <= 1'b0;
`endif
    end else if (start_i) begin
      cnt <= '0;
`ifdef ALU_DIV_EN
      is_div <= op_div_i;
      opnd   <= op_div_i ? b_i : a_i;
      prod   <= {32'b0, (op_div_i ? a_i : b_i)};
`else
      opnd <= a_i;
      prod <= {32'b0, b_i};
`endif
    end else if (en_i) begin
      prod <= res_next_o;
      cnt  <= cnt + 5'd1;
    end
  end

endmodule

// File: rtl/alu_wb_slave.sv
// Wishbone classic ALU coprocessor: bus decode, register file and FSM.
// Define ALU_DIV_EN to build the divider (opcode 6); otherwise opcode 6 gets err.
module alu_wb_slave
  import alu_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0300
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  input  logic        we_i,
  input  logic [3:0]  sel_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        lock_i,
  input  logic        tagn_i,
  output logic        ack_o,
  output logic        err_o,
  output logic        rty_o,
  output logic        tagn_o,
  output logic        busy_o
);

  state_e      state, state_nx;
  logic [31:0] opa, opb, opa_w, opb_w;
  op_e         last_op, new_op;
  logic [63:0] res, res_nx;
  logic        done, div0, go, go_iter, finish;
  logic        ack, err, rty;
  logic [31:0] dat;

  logic        hit, req, busy, op_ok, start, start_iter;
  logic        resp_ack, resp_err, resp_rty, wr_opa, wr_opb;
  logic [31:0] rdata;
  logic        core_done;
  logic [63:0] core_res;
  logic        unused_ok;

  assign unused_ok = ^{lock_i, tagn_i};

  assign hit    = (addr_i[31:8] == BASE_ADDR[31:8]);
  assign req    = cyc_i && stb_i && hit && !(ack || err || rty);
  assign busy   = (state == ST_EXEC) || (state == ST_ITER);
  assign new_op = op_e'(dat_i[2:0]);
  assign start_iter = (new_op == OP_MUL) || ((new_op == OP_DIV) && (opb != '0));

`ifdef ALU_DIV_EN
  assign op_ok = (new_op != OP_RSV);
`else
  assign op_ok = (new_op != OP_RSV) && (new_op != OP_DIV);
`endif

  always_comb begin
    resp_ack = 1'b0;
    resp_err = 1'b0;
    resp_rty = 1'b0;
    rdata    = '0;
    wr_opa   = 1'b0;
    wr_opb   = 1'b0;
    start    = 1'b0;
    if (req) begin
      if (addr_i[1:0] != 2'b00) begin
        resp_err = 1'b1;
      end else begin
        case (addr_i[7:0])
          OFF_OPA: begin
            resp_ack = 1'b1;
            wr_opa   = we_i;
            if (!we_i) rdata = opa;
          end
          OFF_OPB: begin
            resp_ack = 1'b1;
            wr_opb   = we_i;
            if (!we_i) rdata = opb;
          end
          OFF_CTRL: begin
            if (!we_i) begin
              resp_ack = 1'b1;
              rdata    = {29'b0, last_op};
            end else if (busy) begin
              resp_rty = 1'b1;
            end else if (!sel_i[0]) begin
              resp_ack = 1'b1;
            end else if (op_ok) begin
              resp_ack = 1'b1;
              start    = 1'b1;
            end else begin
              resp_err = 1'b1;
            end
          end
          OFF_STATUS: begin
            if (we_i) begin
              resp_err = 1'b1;
            end else begin
              resp_ack        = 1'b1;
              rdata[STAT_BUSY] = busy;
              rdata[STAT_DONE] = done;
              rdata[STAT_DIV0] = div0;
            end
          end
          OFF_RES_LO: begin
            resp_err = we_i;
            resp_ack = !we_i;
            if (!we_i) rdata = res[31:0];
          end
          OFF_RES_HI: begin
            resp_err = we_i;
            resp_ack = !we_i;
            if (!we_i) rdata = res[63:32];
          end
          default: resp_err = 1'b1;
        endcase
      end
    end
  end

  // go is the accepted-start flag from the ack cycle; the FSM leaves IDLE/DONE a cycle later.
  always_comb begin
    state_nx = state;
    finish   = 1'b0;
    res_nx   = exec_result(last_op, opa_w, opb_w);
    case (state)
      ST_IDLE, ST_DONE: state_nx = go ? (go_iter ? ST_ITER : ST_EXEC) : ST_IDLE;
      ST_EXEC: begin
        state_nx = ST_DONE;
        finish   = 1'b1;
      end
      ST_ITER: begin
        res_nx = core_res;
        if (core_done) begin
          state_nx = ST_DONE;
          finish   = 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= ST_IDLE;
      opa     <= '0;
      opb     <= '0;
      opa_w   <= '0;
      opb_w   <= '0;
      last_op <= OP_ADD;
      res     <= '0;
      done    <= 1'b0;
      div0    <= 1'b0;
      go      <= 1'b0;
      go_iter <= 1'b0;
      ack     <= 1'b0;
      err     <= 1'b0;
      rty     <= 1'b0;
      dat     <= '0;
    end else begin
      state   <= state_nx;
      ack     <= resp_ack;
      err     <= resp_err;
      rty     <= resp_rty;
      dat     <= rdata;
      go      <= start;
      go_iter <= start_iter;
      if (wr_opa) opa <= merge_lanes(opa, dat_i, sel_i);
      if (wr_opb) opb <= merge_lanes(opb, dat_i, sel_i);
      if (start) begin
        last_op <= new_op;
        opa_w   <= opa;
        opb_w   <= opb;
        done    <= 1'b0;
        div0    <= 1'b0;
      end
      if (finish) begin
        res  <= res_nx;
        done <= 1'b1;
        div0 <= (state == ST_EXEC) && (last_op == OP_DIV);
      end
    end
  end

  alu_iter_core u_core (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start && start_iter),
    .op_div_i   (new_op == OP_DIV),
    .en_i       (state == ST_ITER),
    .a_i        (opa),
    .b_i        (opb),
    .done_o     (core_done),
    .res_next_o (core_res)
  );

  assign dat_o  = dat;
  assign ack_o  = ack;
  assign err_o  = err;
  assign rty_o  = rty;
  assign tagn_o = 1'b0;
  assign busy_o = busy;

endmodule

// File: tb/tb_alu_wb_slave.sv
// Scoreboard bench for alu_wb_slave: stimulus pushes expected bus responses and
// cycle-exact probe checks; a single monitor process pops and compares them.
module tb_alu_wb_slave;

  localparam logic [31:0] BASE = 32'h0000_0300;
  localparam logic [2:0]  ACK  = 3'b100;
  localparam logic [2:0]  ERR  = 3'b010;
  localparam logic [2:0]  RTY  = 3'b001;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, wdat, rdat;
  logic        we, cyc, stb, lock, tagn_in;
  logic [3:0]  sel;
  logic        ack, err, rty, tagn, busy;

  int checks = 0;
  int errors = 0;

  logic [2:0]  exp_resp[$];
  logic [31:0] exp_dat[$];
  string       exp_name[$];
  string       d_name[$];
  logic [63:0] d_act[$];
  logic [63:0] d_exp[$];

  always #5 clk = ~clk;

  alu_wb_slave #(.BASE_ADDR(BASE)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .addr_i (addr),
    .dat_i  (wdat),
    .dat_o  (rdat),
    .we_i   (we),
    .sel_i  (sel),
    .cyc_i  (cyc),
    .stb_i  (stb),
    .lock_i (lock),
    .tagn_i (tagn_in),
    .ack_o  (ack),
    .err_o  (err),
    .rty_o  (rty),
    .tagn_o (tagn),
    .busy_o (busy)
  );

  // Monitor: sole owner of the check/error counters.
  initial begin
    logic [2:0]  r;
    logic [31:0] d;
    string       n;
    logic [63:0] a, e;
    forever begin
      @(negedge clk);
      if (ack || err || rty) begin
        checks++;
        if (exp_resp.size() == 0) begin
          errors++;
          $display("FAIL unexpected_resp: got resp=%b dat=%h, required no response", {ack, err, rty}, rdat);
        end else begin
          r = exp_resp.pop_front();
          d = exp_dat.pop_front();
          n = exp_name.pop_front();
          if ({ack, err, rty} !== r || rdat !== d) begin
            errors++;
            $display("FAIL %s: got resp=%b dat=%h, required resp=%b dat=%h", n, {ack, err, rty}, rdat, r, d);
          end
        end
      end
      while (d_name.size() > 0) begin
        n = d_name.pop_front();
        a = d_act.pop_front();
        e = d_exp.pop_front();
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL %s: got %h, required %h", n, a, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1);
  end

  task automatic dchk(input string n, input logic [63:0] a, input logic [63:0] e);
    d_name.push_back(n);
    d_act.push_back(a);
    d_exp.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One bus access; returns 1ns after the sampling edge (the response cycle).
  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input string n, input bit expect_resp,
                     input logic [2:0] er, input logic [31:0] ed);
    @(posedge clk);
    #1;
    if (expect_resp) begin
      exp_resp.push_back(er);
      exp_dat.push_back(ed);
      exp_name.push_back(n);
    end
    cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdat = d; sel = s;
    @(posedge clk);
    #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; wdat = '0;
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] d, input string n, input logic [2:0] er);
    bus(1'b1, BASE + {24'b0, off}, d, 4'hF, n, 1'b1, er, 32'h0);
  endtask

  task automatic rd(input logic [7:0] off, input string n, input logic [2:0] er, input logic [31:0] ed);
    bus(1'b0, BASE + {24'b0, off}, 32'h0, 4'hF, n, 1'b1, er, ed);
  endtask

  logic [31:0] lg_exp [3];
  logic [2:0]  lg_op  [3];
  logic [2:0]  rst_op;

  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = '0; wdat = '0;
    sel = 4'h0; lock = 1'b0; tagn_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    dchk("rst_busy", 64'(busy), 64'd0);
    dchk("rst_resp", 64'({ack, err, rty}), 64'd0);
    dchk("rst_dat", 64'(rdat), 64'd0);
    dchk("tagn_zero", 64'(tagn), 64'd0);
    rd(8'h0C, "rst_status", ACK, 32'h0);
    rd(8'h10, "rst_res_lo", ACK, 32'h0);
    rd(8'h14, "rst_res_hi", ACK, 32'h0);
    rd(8'h00, "rst_opa", ACK, 32'h0);
    rd(8'h08, "rst_ctrl", ACK, 32'h0);

    // ADD with carry out
    wr(8'h00, 32'hFFFF_FFFF, "wr_opa_add", ACK);
    wr(8'h04, 32'h0000_0001, "wr_opb_add", ACK);
    wr(8'h08, 32'h0, "ctrl_add", ACK);
    dchk("add_busy_T", 64'(busy), 64'd0);
    rd(8'h0C, "add_status_running", ACK, 32'h1);
    dchk("add_busy_T2", 64'(busy), 64'd0);
    rd(8'h14, "add_res_hi", ACK, 32'h1);
    rd(8'h10, "add_res_lo", ACK, 32'h0);
    rd(8'h0C, "add_status_done", ACK, 32'h2);

    // Held strobe: one response every other cycle
    @(posedge clk);
    #1;
    repeat (2) begin
      exp_resp.push_back(ACK);
      exp_dat.push_back(32'hFFFF_FFFF);
      exp_name.push_back("held_stb_opa");
    end
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = BASE; sel = 4'hF;
    tick(4);
    cyc = 1'b0; stb = 1'b0;

    // SUB with borrow; STATUS shows done cleared by the new CTRL write
    wr(8'h00, 32'h0, "wr_opa_sub", ACK);
    wr(8'h04, 32'h1, "wr_opb_sub", ACK);
    wr(8'h08, 32'h1, "ctrl_sub", ACK);
    rd(8'h0C, "sub_status_running", ACK, 32'h1);
    rd(8'h10, "sub_res_lo", ACK, 32'hFFFF_FFFF);
    rd(8'h14, "sub_res_hi", ACK, 32'h1);

    // Logic ops
    lg_op[0] = 3'd2; lg_exp[0] = 32'h00F0_1200;
    lg_op[1] = 3'd3; lg_exp[1] = 32'hFFF0_FF34;
    lg_op[2] = 3'd4; lg_exp[2] = 32'hFF00_ED34;
    wr(8'h00, 32'hF0F0_1234, "wr_opa_logic", ACK);
    wr(8'h04, 32'h0FF0_FF00, "wr_opb_logic", ACK);
    for (int i = 0; i < 3; i++) begin
      wr(8'h08, {29'b0, lg_op[i]}, "ctrl_logic", ACK);
      tick(1);
      rd(8'h10, $sformatf("logic_op%0d_lo", lg_op[i]), ACK, lg_exp[i]);
      rd(8'h14, $sformatf("logic_op%0d_hi", lg_op[i]), ACK, 32'h0);
    end
    bus(1'b1, BASE, 32'hAAAA_5555, 4'b0011, "wr_opa_lanes", 1'b1, ACK, 32'h0);
    rd(8'h00, "opa_lane_merge", ACK, 32'hF0F0_5555);
    rd(8'h08, "ctrl_readback_xor", ACK, 32'h4);
    tick(1);
    dchk("idle_dat_zero", 64'(rdat), 64'd0);

    // MUL max*max, CTRL write at T+10 gets rty, OPA write while busy accepted
    wr(8'h00, 32'hFFFF_FFFF, "wr_opa_mul", ACK);
    wr(8'h04, 32'hFFFF_FFFF, "wr_opb_mul", ACK);
    wr(8'h08, 32'h5, "ctrl_mul", ACK);
    dchk("mul_busy_T", 64'(busy), 64'd0);
    tick(1);
    dchk("mul_busy_T1", 64'(busy), 64'd1);
    tick(7);
    wr(8'h08, 32'h0, "ctrl_busy_rty", RTY);
    wr(8'h00, 32'h0000_0003, "wr_opa_while_busy", ACK);
    rd(8'h10, "res_lo_prev_while_busy", ACK, 32'hFF00_ED34);
    tick(16);
    rd(8'h0C, "mul_status_T32", ACK, 32'h1);
    dchk("mul_busy_T32", 64'(busy), 64'd1);
    tick(1);
    dchk("mul_busy_T33", 64'(busy), 64'd0);
    rd(8'h0C, "mul_status_done", ACK, 32'h2);
    rd(8'h14, "mul_res_hi", ACK, 32'hFFFF_FFFE);
    rd(8'h10, "mul_res_lo", ACK, 32'h0000_0001);
    rd(8'h08, "ctrl_after_rty", ACK, 32'h5);
    rd(8'h00, "opa_written_busy", ACK, 32'h3);

`ifdef ALU_DIV_EN
    wr(8'h00, 32'd100, "wr_opa_div", ACK);
    wr(8'h04, 32'd7, "wr_opb_div", ACK);
    wr(8'h08, 32'h6, "ctrl_div", ACK);
    tick(1);
    dchk("div_busy_T1", 64'(busy), 64'd1);
    tick(32);
    dchk("div_busy_T33", 64'(busy), 64'd0);
    rd(8'h0C, "div_status_done", ACK, 32'h2);
    rd(8'h10, "div_quot", ACK, 32'd14);
    rd(8'h14, "div_rem", ACK, 32'd2);
    wr(8'h00, 32'd5, "wr_opa_div0", ACK);
    wr(8'h04, 32'd0, "wr_opb_div0", ACK);
    wr(8'h08, 32'h6, "ctrl_div0", ACK);
    tick(1);
    dchk("div0_busy_T1", 64'(busy), 64'd1);
    tick(1);
    dchk("div0_busy_T2", 64'(busy), 64'd0);
    rd(8'h0C, "div0_status", ACK, 32'h6);
    rd(8'h10, "div0_quot", ACK, 32'hFFFF_FFFF);
    rd(8'h14, "div0_rem", ACK, 32'd5);
    rst_op = 3'd6;
`else
    wr(8'h08, 32'h6, "ctrl_div_disabled", ERR);
    tick(1);
    dchk("div_disabled_busy", 64'(busy), 64'd0);
    rd(8'h0C, "div_disabled_status", ACK, 32'h2);
    rd(8'h08, "div_disabled_ctrl", ACK, 32'h5);
    rd(8'h10, "div_disabled_res_lo", ACK, 32'h1);
    rst_op = 3'd5;
`endif

    // Reset during ITER aborts
    wr(8'h00, 32'd100, "wr_opa_rst", ACK);
    wr(8'h04, 32'd7, "wr_opb_rst", ACK);
    wr(8'h08, {29'b0, rst_op}, "ctrl_rst_op", ACK);
    tick(14);
    dchk("rst_op_busy_T14", 64'(busy), 64'd1);
    tick(1);
    rst = 1'b1;
    dchk("rst_op_busy_T15", 64'(busy), 64'd1);
    tick(1);
    rst = 1'b0;
    dchk("abort_busy", 64'(busy), 64'd0);
    dchk("abort_resp", 64'({ack, err, rty}), 64'd0);
    rd(8'h0C, "abort_status", ACK, 32'h0);
    rd(8'h10, "abort_res_lo", ACK, 32'h0);
    rd(8'h14, "abort_res_hi", ACK, 32'h0);
    rd(8'h00, "abort_opa", ACK, 32'h0);

    // Error responses
    wr(8'h08, 32'h7, "ctrl_reserved", ERR);
    tick(1);
    dchk("reserved_busy", 64'(busy), 64'd0);
    rd(8'h18, "rd_unmapped", ERR, 32'h0);
    wr(8'h10, 32'h5, "wr_res_lo", ERR);
    wr(8'h0C, 32'h5, "wr_status", ERR);
    bus(1'b1, BASE + 32'h2, 32'h1234_5678, 4'hF, "wr_misaligned", 1'b1, ERR, 32'h0);
    wr(8'h00, 32'hCAFE_0001, "wr_opa_for_outside", ACK);
    bus(1'b0, 32'h0000_0400, 32'h0, 4'hF, "rd_outside", 1'b0, ACK, 32'h0);
    dchk("outside_resp", 64'({ack, err, rty}), 64'd0);
    dchk("outside_dat", 64'(rdat), 64'd0);
    bus(1'b1, 32'h0000_0000, 32'h5555_5555, 4'hF, "wr_outside", 1'b0, ACK, 32'h0);
    dchk("outside_wr_resp", 64'({ack, err, rty}), 64'd0);
    rd(8'h00, "opa_after_outside", ACK, 32'hCAFE_0001);

    tick(2);
    dchk("scoreboard_drained", 64'(exp_resp.size()), 64'd0);
    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
